// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that shares one 4:1 single-bit mux between four
// requesters. Requester i owns mux data input i (0=a, 1=b, 2=c, 3=d).
// The grant, mux selects and current index are all registered, so the
// selects and the grant always change together at a rising clock edge.
// A requester can hold the mux for at most MAX_HOLD consecutive cycles while
// another requester is waiting. After that the grant rotates.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   req  - level requests, bit i = requester i wants the mux
//   gnt  - registered one-hot grant, all-zero when idle
//   s0   - mux select MSB (granted index bit 1)
//   s1   - mux select LSB (granted index bit 0)
//   busy - high while any grant is asserted (== |gnt)
//   cur  - index of the current or last granted requester (== {s0,s1})
//
// Handshake: req is a level. A requester owns the mux for every cycle its
// gnt bit is high and releases it by dropping req. It must be prepared to
// lose gnt after MAX_HOLD cycles whenever another requester is pending.

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic [1:0] cur
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       last;      // most recently granted index; the search starts after it
    logic [CNT_W-1:0] hold_cnt;  // cycles already held, minus one

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Rotating search: (last+1) .. (last+4) mod 4, first set bit wins.
    // While in GRANT, last is the owner k. The owner is therefore visited
    // last, so any other pending requester is always preferred over k.
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Requests from anyone other than the current owner.
    logic [3:0] others;
    assign others = req & ~gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            s0       <= 1'b0;
            s1       <= 1'b0;
            cur      <= 2'd0;
            busy     <= 1'b0;
            last     <= 2'd3;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // selects and cur keep the last index so the mux stays stable
                    if (found) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << win;
                        {s0, s1} <= win;
                        cur      <= win;
                        busy     <= 1'b1;
                        last     <= win;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[last] || hold_cnt == HOLD_LAST) begin
                        if (others != 4'b0000) begin
                            // hand over in the same edge, no idle bubble
                            gnt      <= 4'b0001 << win;
                            {s0, s1} <= win;
                            cur      <= win;
                            last     <= win;
                            hold_cnt <= '0;
                        end else if (!req[last]) begin
                            state    <= IDLE;
                            gnt      <= 4'b0000;
                            busy     <= 1'b0;
                        end else begin
                            // alone at the limit: counter wraps, grant continues
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter. Two instances share one request bus:
// dut 0 uses MAX_HOLD=4 and dut 1 uses MAX_HOLD=1.

module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt  [2];
    logic       s0   [2];
    logic       s1   [2];
    logic       busy [2];
    logic [1:0] cur  [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt[0]), .s0(s0[0]), .s1(s1[0]), .busy(busy[0]), .cur(cur[0])
    );

    mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt[1]), .s0(s0[1]), .s1(s1[1]), .busy(busy[1]), .cur(cur[1])
    );

    // Reference model: who owns the mux and how many cycles it has held it.
    int owner_m [2];   // -1 when idle
    int last_m  [2];   // last granted index
    int run_m   [2];   // cycles held so far by the owner (1..MAX_HOLD)
    int disp_m  [2];   // index shown on the selects
    int mh_m    [2] = '{4, 1};

    function automatic int pick(input int p, input logic [3:0] r);
        for (int j = 1; j <= 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner_m[m] = -1;
            last_m[m]  = 3;
            run_m[m]   = 0;
            disp_m[m]  = 0;
        end
    endtask

    task automatic model_grant(input int m, input int w);
        owner_m[m] = w;
        last_m[m]  = w;
        disp_m[m]  = w;
        run_m[m]   = 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        int         k;
        logic [3:0] oth;
        for (int m = 0; m < 2; m++) begin
            if (owner_m[m] < 0) begin
                if (r != 4'b0000) model_grant(m, pick(last_m[m], r));
            end else begin
                k   = owner_m[m];
                oth = r & ~(4'b0001 << k);
                if (!r[k]) begin
                    if (oth != 4'b0000) model_grant(m, pick(k, r));
                    else owner_m[m] = -1;
                end else if (run_m[m] == mh_m[m]) begin
                    if (oth != 4'b0000) model_grant(m, pick(k, r));
                    else run_m[m] = 1;
                end else begin
                    run_m[m]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        for (int m = 0; m < 2; m++) begin
            eg = (owner_m[m] < 0) ? 4'b0000 : (4'b0001 << owner_m[m]);
            chk($sformatf("gnt%0d", m),  gnt[m], eg);
            chk($sformatf("sel%0d", m),  {2'b00, s0[m], s1[m]}, 4'(disp_m[m]));
            chk($sformatf("cur%0d", m),  {2'b00, cur[m]}, 4'(disp_m[m]));
            chk($sformatf("busy%0d", m), {3'b000, busy[m]}, {3'b000, owner_m[m] >= 0});
        end
    endtask

    // Drive req, take one edge, advance the model, check 1 time unit later.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // reset state
        do_reset();

        // single requester 0, then release
        cycle(4'b0001);
        chk("first_grant", gnt[0], 4'b0001);
        cycle(4'b0000);
        chk("release_idle", gnt[0], 4'b0000);
        chk("release_sel", {2'b00, s0[0], s1[0]}, 4'b0000);

        // all requesting: 0,1,2,3,0 with 4 cycles each on dut 0
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            cycle(4'b1111);
            chk($sformatf("rr_seq_%0d", n), gnt[0], 4'b0001 << (((n - 1) / 4) % 4));
            chk($sformatf("rr1_seq_%0d", n), gnt[1], 4'b0001 << ((n - 1) % 4));
        end

        // lone holder never loses the grant
        for (int n = 0; n < 10; n++) begin
            cycle(4'b0100);
            chk("lone_hold", gnt[0], 4'b0100);
        end
        cycle(4'b0000);

        // requester 1 then immediate handover to 3
        cycle(4'b0010);
        cycle(4'b0010);
        cycle(4'b1000);
        chk("handover", gnt[0], 4'b1000);
        chk("handover_sel", {2'b00, s0[0], s1[0]}, 4'b0011);

        // idle after 3, then 0 and 3 together: search starts at 0
        cycle(4'b0000);
        cycle(4'b1001);
        chk("wrap_pick", gnt[0], 4'b0001);
        chk("wrap_sel", {2'b00, s0[0], s1[0]}, 4'b0000);
        cycle(4'b0000);

        // asynchronous reset mid-grant
        cycle(4'b0100);
        cycle(4'b0100);
        chk("pre_rst", gnt[0], 4'b0100);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        cycle(4'b0100);
        chk("post_rst", gnt[0], 4'b0100);

        // randomized traffic, with requests sometimes held for several cycles
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
                cycle(r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's 4:1 single-bit mux between four requesters.
- Requester i owns mux data input i: 0=a, 1=b, 2=c, 3=d.
- Drives the mux selects s0/s1 and returns a one-hot grant to the requesters.
- Enforces a bounded hold time so no requester can starve the others.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the mux while others are pending. Legal range is 1..16.
- CNT_W, 4: hold-counter width. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  level request; bit i = requester i wants the mux.
- gnt  output 4  registered one-hot grant; all-zero when idle.
- s0   output 1  mux select MSB = granted index bit 1 (registered).
- s1   output 1  mux select LSB = granted index bit 0 (registered).
- busy output 1  high while any grant is asserted.
- cur  output 2  index of current or last granted requester.

Behaviour:
- Reset (asynchronous, immediate):
  - gnt=0000, s0=0, s1=0, busy=0, cur=0.
  - Internal last pointer=3, so the first search starts at requester 0.
  - hold_cnt=0, state=IDLE.
  - Reset mid-grant drops gnt in the same instant. No state survives reset.
- Encoding: cur={s0,s1} always. Mux mapping: 00->a, 01->b, 10->c, 11->d.
- Selection: search order is (last+1), (last+2), (last+3), (last+4) mod 4. The first set req bit wins.
- States:
  - IDLE:
    - No grant. s0/s1/cur hold the last granted index, keeping the mux stable.
    - If req!=0 at a rising edge: grant the winner at that edge (1-cycle latency from req to gnt/s0/s1). Set hold_cnt=0, go to GRANT.
  - GRANT, requester k holds the mux. At each rising edge, first matching rule applies:
    - (a) req[k]=0 and other req pending: switch to the next winner (searched from k+1) in the same edge. No idle bubble. hold_cnt=0.
    - (b) req[k]=0 and no other req: gnt=0000, busy=0, go to IDLE. last=k.
    - (c) req[k]=1 and hold_cnt==MAX_HOLD-1 and another req pending: switch to the next winner (from k+1). hold_cnt=0.
    - (d) req[k]=1 and hold_cnt==MAX_HOLD-1 and no other req: keep k, hold_cnt=0 (counter wraps, grant continues).
    - (e) otherwise: keep k, hold_cnt+1.
- last is updated to the newly granted index on every grant or switch.
- A requester receiving gnt sees its data on the mux output e in the same cycle gnt is high; s0/s1 change only at clock edges together with gnt.
- MAX_HOLD=1: rule (c)/(d) is evaluated every cycle, giving a pure per-cycle round-robin.
- Requests arriving in the same cycle are resolved purely by search order; no fixed priority exists beyond the rotating pointer.
- gnt is always one-hot or zero. busy == |gnt.

Test Plan:
- Reset then req=0001 -> one cycle later gnt=0001, s0s1=00, busy=1, cur=0. Drop req -> next edge gnt=0000, busy=0, s0s1 stays 00.
- From reset, req=1111 held, MAX_HOLD=4 -> grant sequence 0,1,2,3,0. Each grant lasts exactly 4 cycles; s0s1 steps 00,01,10,11,00 with no gap cycles.
- req=0100 held alone for 10 cycles -> gnt=0100 continuously; s0s1=10 the whole time; hold_cnt wraps with no drop.
- Requester 1 granted; req changes 0010->1000 in one cycle -> next edge gnt=1000, s0s1=11, no idle cycle between grants.
- After a grant to 3 and return to IDLE, assert req=1001 -> requester 0 granted (search starts at 0 after last=3), gnt=0001, s0s1=00.
- Assert rst asynchronously mid-grant (gnt=0100, between edges) -> gnt=0000, busy=0, s0s1=00 immediately. After release with req=0100 -> requester 2 granted after one edge.
